llr_bram_loader: RTL and testbench

LLR_BRAM_LOADER -- requirements
Module: llr_bram_loader

---
 rtl/llr_bram_loader.sv | 115 +++++++++++
 tb/tb_llr_bram_loader.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llr_bram_loader.sv
// Loads one frame of channel LLRs into a BRAM port, quantizing each word to a
// symmetric 4-bit signed value and counting how many words had to be clipped.
module llr_bram_loader #(
  parameter int DEPTH = 64,
  parameter int IN_W  = 8,
  parameter int SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            frm_release,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            in_ready,
  output logic            bram_en,
  output logic            bram_we,
  output logic [6:0]      bram_addr,
  output logic [3:0]      bram_din,
  output logic            frame_done,
  output logic            busy,
  output logic [7:0]      sat_cnt
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic signed [IN_W-1:0] QMAX = IN_W'(7);
  localparam logic signed [IN_W-1:0] QMIN = -QMAX;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CW-1:0]          cnt;
  logic                   hs;
  logic                   last_word;
  logic signed [IN_W-1:0] q;
  logic [3:0]             q_sat;
  logic                   q_clip;

  assign hs        = in_valid && in_ready;
  assign last_word = (cnt == CW'(DEPTH - 1));

  // Clip to +/-7 so the 4-bit code stays symmetric and -8 is never emitted.
  assign q = $signed(in_data) >>> SHIFT;

  always_comb begin
    q_sat  = 4'(q);
    q_clip = 1'b0;
    if (q > QMAX) begin
      q_sat  = 4'sd7;
      q_clip = 1'b1;
    end else if (q < QMIN) begin
      q_sat  = 4'b1001;
      q_clip = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_word) state_d = FULL;
      end
      FULL: begin
        busy = 1'b1;
        if (frm_release) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // sat_cnt survives frm_release so the decoder can still read it after FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      sat_cnt <= '0;
    end else if (state_q == IDLE && start) begin
      cnt     <= '0;
      sat_cnt <= '0;
    end else if (hs) begin
      cnt <= cnt + 1'b1;
      if (q_clip && sat_cnt != 8'hFF) sat_cnt <= sat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      frame_done <= 1'b0;
    end else begin
      bram_en    <= hs;
      bram_we    <= hs;
      frame_done <= hs && last_word;
      if (hs) begin
        bram_addr <= 7'(cnt);
        bram_din  <= q_sat;
      end
    end
  end

endmodule

// File: tb/tb_llr_bram_loader.sv
// Scoreboard bench for llr_bram_loader: stimulus tasks push expected BRAM writes,
// a negedge monitor pops and compares them as the DUT writes.
module tb_llr_bram_loader;

  localparam int DEPTH = 64;
  localparam int IN_W  = 8;
  localparam int SHIFT = 2;

  logic       clk;
  logic       rst;
  logic       start, frm_release, in_valid;
  logic [7:0] in_data;
  logic       in_ready, bram_en, bram_we, frame_done, busy;
  logic [6:0] bram_addr;
  logic [3:0] bram_din;
  logic [7:0] sat_cnt;

  logic       start2, rel2, valid2;
  logic [7:0] data2;
  logic       ready2, en2, we2, fd2, busy2;
  logic [6:0] addr2;
  logic [3:0] din2;
  logic [7:0] sat2;

  typedef struct packed {
    logic [6:0] addr;
    logic [3:0] din;
    logic       last;
  } wr_t;

  typedef enum int {M_IDLE, M_LOAD, M_FULL} mstate_t;

  wr_t     sbQ[$];
  wr_t     d2Q[$];
  wr_t     monEntry;
  mstate_t mState = M_IDLE;
  int      mCnt = 0;
  int      mSat = 0;
  logic    expectAccept = 1'b0;
  logic    weDue = 1'b0;
  int      fdCount = 0;
  int      assertCount = 0;
  int      failCount = 0;

  llr_bram_loader #(.DEPTH(DEPTH), .IN_W(IN_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .start(start), .frm_release(frm_release),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .frame_done(frame_done), .busy(busy), .sat_cnt(sat_cnt)
  );

  llr_bram_loader #(.DEPTH(2), .IN_W(IN_W), .SHIFT(SHIFT)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .frm_release(rel2),
    .in_valid(valid2), .in_data(data2), .in_ready(ready2),
    .bram_en(en2), .bram_we(we2), .bram_addr(addr2),
    .bram_din(din2), .frame_done(fd2), .busy(busy2), .sat_cnt(sat2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void qModel(input logic [7:0] d, output logic [3:0] qd, output logic clip);
    int v;
    v = int'($signed(d)) >>> SHIFT;
    clip = (v > 7) || (v < -7);
    if (v > 7) v = 7;
    else if (v < -7) v = -7;
    qd = v[3:0];
  endfunction

  // Write monitor: a write must appear exactly one cycle after each expected accept.
  always @(negedge clk) begin
    assertCount++;
    if (bram_we !== weDue || bram_en !== weDue) begin
      failCount++;
      $display("[TB] FAIL write_timing: we=%b en=%b expected %b at %0t", bram_we, bram_en, weDue, $time);
    end
    if (bram_we === 1'b1) begin
      assertCount++;
      if (sbQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL unexpected_write: addr=%0d din=%h at %0t", bram_addr, bram_din, $time);
      end else begin
        monEntry = sbQ.pop_front();
        if ({bram_addr, bram_din, frame_done} !== {monEntry.addr, monEntry.din, monEntry.last}) begin
          failCount++;
          $display("[TB] FAIL write_data: addr=%0d din=%h fd=%b expected addr=%0d din=%h fd=%b",
                   bram_addr, bram_din, frame_done, monEntry.addr, monEntry.din, monEntry.last);
        end
      end
    end else begin
      assertCount++;
      if (frame_done !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL stray_frame_done: frame_done=%b expected 0 at %0t", frame_done, $time);
      end
    end
    if (frame_done === 1'b1) fdCount++;
    weDue = expectAccept;
  end

  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic st, input logic rel);
    logic [3:0] qd;
    logic       clip;
    wr_t        e;
    @(posedge clk);
    #1;
    in_valid     = v;
    in_data      = d;
    start        = st;
    frm_release  = rel;
    expectAccept = 1'b0;
    case (mState)
      M_IDLE: if (st) begin
        mState = M_LOAD;
        mCnt   = 0;
        mSat   = 0;
      end
      M_LOAD: if (v) begin
        qModel(d, qd, clip);
        e.addr = 7'(mCnt);
        e.din  = qd;
        e.last = (mCnt == DEPTH - 1);
        sbQ.push_back(e);
        expectAccept = 1'b1;
        if (clip && mSat < 255) mSat++;
        mCnt++;
        if (e.last) mState = M_FULL;
      end
      M_FULL: if (rel) mState = M_IDLE;
      default: mState = M_IDLE;
    endcase
  endtask

  task automatic test_reset;
    #1;
    assertCount++;
    if ({in_ready, bram_en, bram_we, frame_done, busy} !== 5'b0) begin
      failCount++;
      $display("[TB] FAIL reset_flags: ready/en/we/fd/busy=%b expected 00000", {in_ready, bram_en, bram_we, frame_done, busy});
    end
    assertCount++;
    if ({bram_addr, bram_din, sat_cnt} !== 19'b0) begin
      failCount++;
      $display("[TB] FAIL reset_data: addr=%h din=%h sat=%h expected 0", bram_addr, bram_din, sat_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'h55, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    assertCount++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL idle_ignores: busy=%b ready=%b expected 0 0", busy, in_ready);
    end
  endtask

  task automatic finish_frame_checks(input string name);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    assertCount++;
    if (fdCount != 1) begin
      failCount++;
      $display("[TB] FAIL %s_frame_done_count: got %0d expected 1", name, fdCount);
    end
    assertCount++;
    if (sbQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL %s_missing_writes: %0d pending expected 0", name, sbQ.size());
    end
    assertCount++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL %s_full_state: busy=%b ready=%b expected 1 0", name, busy, in_ready);
    end
  endtask

  task automatic release_frame(input string name);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    assertCount++;
    if (busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL %s_release: busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_basic_load;
    fdCount = 0;
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'(4 * i), 1'b0, 1'b0);
    finish_frame_checks("basic");
    assertCount++;
    if (sat_cnt !== 8'(mSat)) begin
      failCount++;
      $display("[TB] FAIL basic_sat_cnt: got %0d expected %0d", sat_cnt, mSat);
    end
    repeat (3) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    assertCount++;
    if (busy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL basic_busy_hold: busy=%b expected 1", busy);
    end
    release_frame("basic");
    assertCount++;
    if (sat_cnt !== 8'(mSat)) begin
      failCount++;
      $display("[TB] FAIL basic_sat_hold: got %0d expected %0d", sat_cnt, mSat);
    end
  endtask

  task automatic test_quantization;
    logic [7:0] qv [5];
    qv = '{8'h7F, 8'h80, 8'hFC, 8'h1C, 8'hE4};
    fdCount = 0;
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, qv[i], 1'b0, 1'b0);
    for (int i = 5; i < DEPTH; i++) drive_cycle(1'b1, 8'h00, 1'b0, 1'b0);
    finish_frame_checks("quant");
    assertCount++;
    if (sat_cnt !== 8'd2) begin
      failCount++;
      $display("[TB] FAIL quant_sat_cnt: got %0d expected 2", sat_cnt);
    end
    release_frame("quant");
  endtask

  task automatic test_backpressure;
    int guard;
    fdCount = 0;
    guard = 0;
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    while (mState == M_LOAD && guard < 2000) begin
      drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 7) == 0));
      guard++;
    end
    assertCount++;
    if (mState != M_FULL) begin
      failCount++;
      $display("[TB] FAIL backpressure_timeout: %0d words after %0d cycles expected %0d", mCnt, guard, DEPTH);
    end
    finish_frame_checks("backpressure");
    assertCount++;
    if (sat_cnt !== 8'(mSat)) begin
      failCount++;
      $display("[TB] FAIL backpressure_sat_cnt: got %0d expected %0d", sat_cnt, mSat);
    end
    release_frame("backpressure");
  endtask

  task automatic test_full_blocking;
    fdCount = 0;
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 8'h40, 1'b1, 1'b0);
      assertCount++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL full_block: ready=%b busy=%b expected 0 1", in_ready, busy);
      end
    end
    finish_frame_checks("full");
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    assertCount++;
    if (busy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL full_release_early: busy=%b expected 1", busy);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    assertCount++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL full_release: busy=%b ready=%b expected 0 0", busy, in_ready);
    end
  endtask

  task automatic test_reset_midframe;
    fdCount = 0;
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, 8'(3 * i + 1), 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    in_valid     = 1'b1;
    in_data      = 8'h7F;
    expectAccept = 1'b0;
    mState       = M_IDLE;
    mCnt         = 0;
    mSat         = 0;
    #1;
    assertCount++;
    if ({in_ready, bram_en, bram_we, frame_done, busy} !== 5'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_flags: ready/en/we/fd/busy=%b expected 00000", {in_ready, bram_en, bram_we, frame_done, busy});
    end
    assertCount++;
    if ({bram_addr, bram_din, sat_cnt} !== 19'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_data: addr=%h din=%h sat=%h expected 0", bram_addr, bram_din, sat_cnt);
    end
    assertCount++;
    if (sbQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL midreset_pending: %0d writes outstanding expected 0", sbQ.size());
    end
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive_cycle(1'b1, 8'h11, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    assertCount++;
    if (fdCount != 0 || in_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_abandon: frame_done count=%0d ready=%b expected 0 0", fdCount, in_ready);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    finish_frame_checks("reload");
    release_frame("reload");
  endtask

  task automatic test_depth2;
    wr_t        e;
    logic [3:0] qd;
    logic       clip;
    @(posedge clk);
    #1 start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    valid2 = 1'b1;
    data2  = 8'h10;
    qModel(data2, qd, clip);
    d2Q.push_back('{addr: 7'd0, din: qd, last: 1'b0});
    @(posedge clk);
    #1;
    data2 = 8'hF0;
    qModel(data2, qd, clip);
    d2Q.push_back('{addr: 7'd1, din: qd, last: 1'b1});
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      e = d2Q.pop_front();
      assertCount++;
      if ({we2, en2, addr2, din2, fd2} !== {2'b11, e.addr, e.din, e.last}) begin
        failCount++;
        $display("[TB] FAIL depth2_write%0d: we=%b addr=%0d din=%h fd=%b expected we=1 addr=%0d din=%h fd=%b",
                 w, we2, addr2, din2, fd2, e.addr, e.din, e.last);
      end
      @(posedge clk);
      #1 valid2 = 1'b0;
    end
    assertCount++;
    if (busy2 !== 1'b1 || ready2 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL depth2_full: busy=%b ready=%b expected 1 0", busy2, ready2);
    end
    @(negedge clk);
    assertCount++;
    if (we2 !== 1'b0 || fd2 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL depth2_extra_write: we=%b fd=%b expected 0 0", we2, fd2);
    end
    @(posedge clk);
    #1 rel2 = 1'b1;
    @(posedge clk);
    #1 rel2 = 1'b0;
    assertCount++;
    if (busy2 !== 1'b0 || sat2 !== 8'd0) begin
      failCount++;
      $display("[TB] FAIL depth2_release: busy=%b sat=%0d expected 0 0", busy2, sat2);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    frm_release = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    start2      = 1'b0;
    rel2        = 1'b0;
    valid2      = 1'b0;
    data2       = 8'h00;
    $display("[TB] starting llr_bram_loader bench");
    test_reset();
    test_basic_load();
    test_quantization();
    test_backpressure();
    test_full_blocking();
    test_reset_midframe();
    test_depth2();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
